// File: rtl/toothless_pkg.sv
// Shared types for the memory port arbiter.
//   arb_state_e : arbiter FSM state encoding
//   arb_owner_e : requester identity (instruction fetch or load/store unit)
//   wait_state  : maps an owner to the state that waits for its response
package toothless_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_WAIT_IF  = 2'd1,
    ARB_WAIT_LSU = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_IF  = 1'b0,
    OWNER_LSU = 1'b1
  } arb_owner_e;

  function automatic arb_state_e wait_state(arb_owner_e owner);
    return (owner == OWNER_LSU) ? ARB_WAIT_LSU : ARB_WAIT_IF;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// (IF) and the load/store unit (LSU). One transaction outstanding at a time;
// the response is routed back to whichever requester owns it.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_req/addr -> gnt/rvalid/rdata            instruction fetch (read only)
//   lsu_req/we/be/addr/wdata -> gnt/rvalid/rdata  load/store
//   mem_req/we/be/addr/wdata, mem_gnt/rvalid/rdata  memory side
//   busy_o                   a transaction is outstanding
//   err_o                    memory response arrived with nothing outstanding
//
// Build option: define MEM_ARB_ROUND_ROBIN_EN to alternate between the two
// requesters under contention; otherwise LSU has fixed priority over IF.
//
// state        | meaning
// -------------+------------------------------------------------------------
// ARB_IDLE     | arbitrating; mem request driven from the picked requester
// ARB_WAIT_IF  | IF transaction accepted, waiting for mem_rvalid_i
// ARB_WAIT_LSU | LSU transaction accepted, waiting for mem_rvalid_i
module mem_port_arbiter
  import toothless_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  output logic                    if_gnt_o,
  output logic                    if_rvalid_o,
  output logic [DATA_WIDTH-1:0]   if_rdata_o,
  input  logic                    lsu_req_i,
  input  logic                    lsu_we_i,
  input  logic [DATA_WIDTH/8-1:0] lsu_be_i,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr_i,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata_i,
  output logic                    lsu_gnt_o,
  output logic                    lsu_rvalid_o,
  output logic [DATA_WIDTH-1:0]   lsu_rdata_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    busy_o,
  output logic                    err_o
);

  arb_state_e state_q, state_d;
  arb_owner_e pick;
  logic       pick_valid;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  arb_owner_e last_owner_q, last_owner_d;
`endif

  // Pick is recomputed every IDLE cycle; nothing is locked until mem_gnt_i.
  always_comb begin : pick_logic
    pick_valid = if_req_i | lsu_req_i;
    pick       = OWNER_LSU;
    if (if_req_i && lsu_req_i) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      pick = (last_owner_q == OWNER_IF) ? OWNER_LSU : OWNER_IF;
`else
      pick = OWNER_LSU;
`endif
    end else if (if_req_i) begin
      pick = OWNER_IF;
    end
  end

  // Every output is forced low while rst is high, including the
  // combinational request path that would otherwise follow if_req_i.
  always_comb begin : fsm_comb
    state_d      = state_q;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_be_o     = '0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    if_gnt_o     = 1'b0;
    lsu_gnt_o    = 1'b0;
    if_rvalid_o  = 1'b0;
    lsu_rvalid_o = 1'b0;
    if_rdata_o   = '0;
    lsu_rdata_o  = '0;
    busy_o       = 1'b0;
    err_o        = 1'b0;
    if (!rst) begin
      if_rdata_o  = mem_rdata_i;
      lsu_rdata_o = mem_rdata_i;
      case (state_q)
        ARB_IDLE: begin
          err_o = mem_rvalid_i;
          if (pick_valid) begin
            mem_req_o = 1'b1;
            if (pick == OWNER_LSU) begin
              mem_we_o    = lsu_we_i;
              mem_be_o    = lsu_be_i;
              mem_addr_o  = lsu_addr_i;
              mem_wdata_o = lsu_wdata_i;
              lsu_gnt_o   = mem_gnt_i;
            end else begin
              mem_be_o   = '1;
              mem_addr_o = if_addr_i;
              if_gnt_o   = mem_gnt_i;
            end
            if (mem_gnt_i) state_d = wait_state(pick);
          end
        end
        ARB_WAIT_IF: begin
          busy_o      = 1'b1;
          if_rvalid_o = mem_rvalid_i;
          if (mem_rvalid_i) state_d = ARB_IDLE;
        end
        ARB_WAIT_LSU: begin
          busy_o       = 1'b1;
          lsu_rvalid_o = mem_rvalid_i;
          if (mem_rvalid_i) state_d = ARB_IDLE;
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_comb begin : last_owner_comb
    last_owner_d = last_owner_q;
    if (state_q == ARB_IDLE && pick_valid && mem_gnt_i) last_owner_d = pick;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_owner_q <= OWNER_IF;
`endif
    end else begin
      state_q <= state_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        lsu_req_i = 1'b0;
  logic        lsu_we_i = 1'b0;
  logic [3:0]  lsu_be_i = '0;
  logic [31:0] lsu_addr_i = '0;
  logic [31:0] lsu_wdata_i = '0;
  logic        lsu_gnt_o, lsu_rvalid_o;
  logic [31:0] lsu_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        busy_o, err_o;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_be_i(lsu_be_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt_o),
    .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  typedef struct packed {
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        if_gnt;
    logic        lsu_gnt;
    logic        if_rv;
    logic        lsu_rv;
    logic        busy;
    logic        err;
  } ctl_t;

  // One cycle of directed stimulus and its hand-derived expectation.
  // sel: which requester drives the memory bus (0 none, 1 IF, 2 LSU).
  typedef struct {
    logic rst, ifr, lsr, we, g, rv;
    int   sel;
    logic ig, lg, ir, lr, bz, er;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: queue of outstanding owners (1 IF, 2 LSU), at most one.
  int   pend_q[$];
  int   last_win = 1;
  ctl_t m_exp;
  int   m_win;
  ctl_t act;

  function automatic int choose(logic ir, logic lr);
    if (ir && lr) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      return (last_win == 2) ? 1 : 2;
`else
      return 2;
`endif
    end
    if (lr) return 2;
    if (ir) return 1;
    return 0;
  endfunction

  task automatic model_eval();
    m_exp = '0;
    m_win = 0;
    if (!rst) begin
      if (pend_q.size() == 0) begin
        m_exp.err = mem_rvalid_i;
        m_win = choose(if_req_i, lsu_req_i);
        if (m_win == 1) begin
          m_exp.mem_req = 1'b1;
          m_exp.be      = 4'hF;
          m_exp.addr    = if_addr_i;
          m_exp.if_gnt  = mem_gnt_i;
        end else if (m_win == 2) begin
          m_exp.mem_req = 1'b1;
          m_exp.mem_we  = lsu_we_i;
          m_exp.be      = lsu_be_i;
          m_exp.addr    = lsu_addr_i;
          m_exp.wdata   = lsu_wdata_i;
          m_exp.lsu_gnt = mem_gnt_i;
        end
      end else begin
        m_exp.busy = 1'b1;
        if (mem_rvalid_i) begin
          if (pend_q[0] == 1) m_exp.if_rv = 1'b1;
          else m_exp.lsu_rv = 1'b1;
        end
      end
    end
  endtask

  task automatic model_clock();
    if (rst) begin
      pend_q.delete();
      last_win = 1;
    end else if (pend_q.size() == 0) begin
      if (m_win != 0 && mem_gnt_i) begin
        pend_q.push_back(m_win);
        last_win = m_win;
      end
    end else if (mem_rvalid_i) begin
      void'(pend_q.pop_front());
    end
  endtask

  // Inputs are set at the falling edge; outputs sampled 2 ns later.
  task automatic step();
    #2;
    model_eval();
    act = {mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
           if_gnt_o, lsu_gnt_o, if_rvalid_o, lsu_rvalid_o, busy_o, err_o};
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic chk(string nm, logic [95:0] a, logic [95:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  vec_t vecs[18];
  int   exp_g[6];
  logic lsu_done;

  initial begin
    //          rst ifr lsr we g  rv sel ig lg ir lr bz er
    vecs[0]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[3]  = '{0, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0};
    vecs[4]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0};
    vecs[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[6]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
    vecs[7]  = '{0, 0, 1, 1, 0, 0, 2, 0, 0, 0, 0, 0, 0};
    vecs[8]  = '{0, 0, 1, 1, 0, 0, 2, 0, 0, 0, 0, 0, 0};
    vecs[9]  = '{0, 0, 1, 1, 1, 0, 2, 0, 1, 0, 0, 0, 0};
    vecs[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0};
    vecs[11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0};
    vecs[12] = '{0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    vecs[13] = '{0, 0, 1, 0, 1, 0, 2, 0, 1, 0, 0, 0, 0};
    vecs[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    vecs[15] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[16] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
    vecs[17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    @(negedge clk);

    // Directed table: reset with IF pending, IF read, stray rvalid, stalled
    // store, non-locked re-arbitration, reset while waiting on the LSU.
    for (int i = 0; i < 18; i++) begin
      ctl_t e;
      rst          = vecs[i].rst;
      if_req_i     = vecs[i].ifr;
      if_addr_i    = 32'h0000_0040;
      lsu_req_i    = vecs[i].lsr;
      lsu_we_i     = vecs[i].we;
      lsu_be_i     = 4'b0011;
      lsu_addr_i   = 32'h0000_0100;
      lsu_wdata_i  = 32'h0000_1234;
      mem_gnt_i    = vecs[i].g;
      mem_rvalid_i = vecs[i].rv;
      mem_rdata_i  = 32'hDEAD_BEEF;
      step();
      e = '0;
      if (vecs[i].sel == 1) begin
        e.mem_req = 1'b1; e.be = 4'hF; e.addr = 32'h40;
      end else if (vecs[i].sel == 2) begin
        e.mem_req = 1'b1; e.mem_we = vecs[i].we; e.be = 4'b0011;
        e.addr = 32'h100; e.wdata = 32'h1234;
      end
      e.if_gnt = vecs[i].ig;  e.lsu_gnt = vecs[i].lg;
      e.if_rv  = vecs[i].ir;  e.lsu_rv  = vecs[i].lr;
      e.busy   = vecs[i].bz;  e.err     = vecs[i].er;
      chk($sformatf("vec%0d", i), act, e);
      if (vecs[i].ir) chk($sformatf("vec%0d_if_rdata", i), if_rdata_o, 32'hDEAD_BEEF);
      if (vecs[i].lr) chk($sformatf("vec%0d_lsu_rdata", i), lsu_rdata_o, 32'hDEAD_BEEF);
    end

    // Contention: both requesting, memory always accepts, response one
    // cycle later. Grant code per cycle: 0 none, 1 IF, 2 LSU.
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_g = '{2, 0, 1, 0, 2, 0};
`else
    exp_g = '{2, 0, 1, 0, 1, 0};
`endif
    rst = 1'b1; if_req_i = 1'b0; lsu_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    step();
    rst = 1'b0;
    lsu_done = 1'b0;
    lsu_we_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      logic [2:0] e3;
      if_req_i     = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      lsu_req_i    = 1'b1;
`else
      lsu_req_i    = ~lsu_done;
`endif
      mem_gnt_i    = 1'b1;
      mem_rvalid_i = (k % 2 == 1);
      step();
      e3 = {exp_g[k] == 1, exp_g[k] == 2, k % 2 == 1};
      chk($sformatf("contend%0d_gnt_busy", k), {act.if_gnt, act.lsu_gnt, act.busy}, e3);
      chk($sformatf("contend%0d_model", k), act, m_exp);
      if (act.lsu_gnt) lsu_done = 1'b1;
    end

    // Randomized traffic against the reference model.
    if_req_i = 1'b0; lsu_req_i = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) < 2);
      if (!if_req_i || act.if_gnt || $urandom_range(0, 9) == 0) begin
        if_req_i  = 1'($urandom_range(0, 1));
        if_addr_i = $urandom;
      end
      if (!lsu_req_i || act.lsu_gnt || $urandom_range(0, 9) == 0) begin
        lsu_req_i   = 1'($urandom_range(0, 1));
        lsu_we_i    = 1'($urandom_range(0, 1));
        lsu_be_i    = 4'($urandom_range(0, 15));
        lsu_addr_i  = $urandom;
        lsu_wdata_i = $urandom;
      end
      mem_gnt_i    = 1'($urandom_range(0, 1));
      mem_rvalid_i = ($urandom_range(0, 9) < 3);
      mem_rdata_i  = $urandom;
      step();
      chk("rand_ctl", act, m_exp);
      if (m_exp.if_rv)  chk("rand_if_rdata", if_rdata_o, mem_rdata_i);
      if (m_exp.lsu_rv) chk("rand_lsu_rdata", lsu_rdata_o, mem_rdata_i);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
